seq_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier for the calculator datapath. It replaces the single-cycle registered N×N multiply with a multi-cycle unit that has a start/done handshake, a selectable signed or unsigned mode, and a full 2N-bit product. The range check is no longer a simulation message: it is a registered hardware overflow flag that the calculator control logic consumes directly.

---
 rtl/seq_mult_pkg.sv | 16 +
 rtl/seq_mult_ctrl.sv | 52 +++++
 rtl/seq_multiplier.sv | 92 +++++++++
 tb/tb_seq_multiplier.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int DEF_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Multiplier sequencer: FSM, step counter and datapath strobes.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic ready,
  output logic done,
  output logic load,
  output logic step,
  output logic finish
);

  localparam int CW = cnt_w(N);

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;

  assign ready  = (state != RUN);
  assign done   = (state == DONE);
  assign load   = start & ready;
  assign step   = (state == RUN);
  assign finish = step && (cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (load)
        cnt <= '0;
      else if (step)
        cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (finish) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier, signed/unsigned, with
// registered overflow flag for the calculator control.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   in1,
  input  logic [N-1:0]   in2,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic           ovf
);

  logic load;
  logic step;
  logic finish;

  seq_mult_ctrl #(.N(N)) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ready  (ready),
    .done   (done),
    .load   (load),
    .step   (step),
    .finish (finish)
  );

  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [2*N:0]   acc;
  logic           neg;
  logic           smode;

  logic [N-1:0]   abs1;
  logic [N-1:0]   abs2;
  logic [N:0]     upper_sum;
  logic [2*N:0]   acc_nx;
  logic [2*N-1:0] mag;
  logic [2*N-1:0] res;
  logic           ovf_nx;

  // -2^(N-1) negates to itself, which read unsigned is the right magnitude
  always_comb begin
    abs1 = (signed_mode && in1[N-1]) ? ('0 - in1) : in1;
    abs2 = (signed_mode && in2[N-1]) ? ('0 - in2) : in2;
  end

  always_comb begin
    upper_sum = acc[2*N:N] + (mplier[0] ? {1'b0, mcand} : '0);
    acc_nx    = {1'b0, upper_sum, acc[N-1:1]};
    mag       = acc_nx[2*N-1:0];
    res       = neg ? ('0 - mag) : mag;
    if (smode)
      ovf_nx = ~((&res[2*N-1:N-1]) | ~(|res[2*N-1:N-1]));
    else
      ovf_nx = |res[2*N-1:N];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      smode   <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
    end else if (load) begin
      mcand   <= abs1;
      mplier  <= abs2;
      acc     <= '0;
      neg     <= signed_mode & (in1[N-1] ^ in2[N-1]);
      smode   <= signed_mode;
      product <= '0;
    end else if (step) begin
      acc    <= acc_nx;
      mplier <= mplier >> 1;
      if (finish) begin
        product <= res;
        ovf     <= ovf_nx;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized and directed checks of seq_multiplier against
// a plain-arithmetic reference model.
module tb_seq_multiplier;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          signed_mode;
  logic [N-1:0]  in1;
  logic [N-1:0]  in2;
  logic          ready;
  logic          done;
  logic [2*N-1:0] product;
  logic          ovf;

  int nchecks = 0;
  int nerrs   = 0;

  seq_multiplier #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .in1         (in1),
    .in2         (in2),
    .ready       (ready),
    .done        (done),
    .product     (product),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic sm,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    longint sa;
    longint sb;
    longint p;
    logic [15:0] pr;
    logic o;
    sa = sm ? longint'($signed(a)) : longint'(a);
    sb = sm ? longint'($signed(b)) : longint'(b);
    p  = sa * sb;
    pr = p[15:0];
    if (sm) o = (p < -128) || (p > 127);
    else    o = (p > 255);
    return {o, pr};
  endfunction

  task automatic issue(input logic sm, input logic [7:0] a,
                       input logic [7:0] b);
    start       = 1'b1;
    signed_mode = sm;
    in1         = a;
    in2         = b;
  endtask

  task automatic accept_edge();
    @(posedge clk);
    #1;
    start = 1'b0;
    in1   = 8'($urandom);
    in2   = 8'($urandom);
    check("accept_ready", 32'(ready), 32'd0);
    check("accept_prod", 32'(product), 32'd0);
  endtask

  task automatic wait_done(output int lat, output int rlow);
    lat  = 0;
    rlow = 1;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (!ready) rlow++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic sm,
                              input logic [7:0] a, input logic [7:0] b);
    logic [16:0] m;
    m = model(sm, a, b);
    check({tag, "_prod"}, 32'(product), 32'(m[15:0]));
    check({tag, "_ovf"}, 32'(ovf), 32'(m[16]));
  endtask

  task automatic do_op(input string tag, input logic sm,
                       input logic [7:0] a, input logic [7:0] b);
    int lat;
    int rlow;
    @(negedge clk);
    issue(sm, a, b);
    accept_edge();
    wait_done(lat, rlow);
    check({tag, "_lat"}, 32'(lat), 32'(N));
    check({tag, "_rlow"}, 32'(rlow), 32'(N));
    check_result(tag, sm, a, b);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(product), 32'(model(sm, a, b) & 17'hFFFF));
  endtask

  initial begin
    int lat;
    int rlow;
    rst         = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    in1         = '0;
    in2         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_prod", 32'(product), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("u17x3", 1'b0, 8'd17, 8'd3);
    check("u17x3_val", 32'(product), 32'h0033);
    do_op("u255x2", 1'b0, 8'd255, 8'd2);
    check("u255x2_val", 32'(product), 32'h01FE);
    do_op("u255x255", 1'b0, 8'd255, 8'd255);
    check("u255x255_val", 32'(product), 32'hFE01);
    do_op("s-3x5", 1'b1, 8'hFD, 8'h05);
    check("s-3x5_val", 32'(product), 32'hFFF1);
    do_op("s-128x1", 1'b1, 8'h80, 8'h01);
    check("s-128x1_val", 32'(product), 32'hFF80);
    do_op("s0x-5", 1'b1, 8'h00, 8'hFB);
    do_op("s-128x-128", 1'b1, 8'h80, 8'h80);
    check("s-128x-128_val", 32'(product), 32'h4000);
    check("s-128x-128_ovfv", 32'(ovf), 32'd1);

    // asynchronous reset mid-run; ovf still set from the previous op
    @(negedge clk);
    issue(1'b0, 8'd9, 8'd3);
    accept_edge();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    check("arst_prod", 32'(product), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("post_rst", 1'b0, 8'd9, 8'd3);
    check("post_rst_val", 32'(product), 32'h001B);

    // start during RUN is ignored
    @(negedge clk);
    issue(1'b0, 8'd9, 8'd3);
    accept_edge();
    repeat (3) @(posedge clk);
    @(negedge clk);
    issue(1'b0, 8'd2, 8'd2);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, rlow);
    check("ign_val", 32'(product), 32'h001B);
    check("ign_done", 32'(done), 32'd1);

    // back-to-back start in the DONE cycle
    issue(1'b0, 8'd6, 8'd7);
    accept_edge();
    wait_done(lat, rlow);
    check("b2b_lat", 32'(lat), 32'(N));
    check("b2b_val", 32'(product), 32'h002A);
    check_result("b2b", 1'b0, 8'd6, 8'd7);

    for (int i = 0; i < 30; i++) begin
      do_op("rand", 1'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
